// File: rtl/demux_pkg.sv
// demux_pkg: shared constants and helpers for demux_stream_1_n.
package demux_pkg;
  localparam int STAT_W = 16;
  localparam logic [STAT_W-1:0] STAT_MAX = 16'hFFFF;
  function automatic int sel_width(input int n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/demux_stream_1_n_slot.sv
// demux_slot: one-entry valid/ready holding register for one output channel.
module demux_slot
  import demux_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_load,
  input  logic         i_drain,
  input  logic [W-1:0] i_data,
  output logic         o_valid,
  output logic [W-1:0] o_data
);
  logic         r_valid;
  logic [W-1:0] r_data;
  // data is kept after a drain so the output holds its last word
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else begin
      r_valid <= i_load | (r_valid & ~i_drain);
      if (i_load) r_data <= i_data;
    end
  assign o_valid = r_valid;
  assign o_data  = r_data;
endmodule

// File: rtl/demux_stream_1_n.sv
// demux_stream_1_n: registered 1-to-N stream demux with per-channel one-entry slots.
// Define DEMUX_STATS_EN to build saturating per-channel delivered-word counters.
module demux_stream_1_n
  import demux_pkg::*;
#(
  parameter int bus_size = 4,
  parameter int num_ch = 4,
  localparam int SEL_W = sel_width(num_ch)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [bus_size-1:0]        in,
  input  logic [SEL_W-1:0]           select,
  output logic [num_ch-1:0]          out_valid,
  input  logic [num_ch-1:0]          out_ready,
  output logic [num_ch*bus_size-1:0] out_data,
  output logic                       sel_err,
  input  logic [SEL_W-1:0]           stat_sel,
  output logic [STAT_W-1:0]          stat_count
);
  localparam logic [SEL_W:0] NCH = (SEL_W+1)'(num_ch);
  logic              w_sel_ok;
  logic              w_blocked;
  logic [num_ch-1:0] w_load;
  logic [num_ch-1:0] w_drain;
  logic              r_sel_err;
  assign w_sel_ok = {1'b0, select} < NCH;
  // out-of-range selects never match a channel, so they are never blocked
  always_comb begin
    w_blocked = 1'b0;
    w_load    = '0;
    for (int i = 0; i < num_ch; i++)
      if (select == SEL_W'(i)) begin
        w_blocked = out_valid[i] & ~out_ready[i];
        w_load[i] = in_valid & ~w_blocked;
      end
  end
  assign in_ready = ~w_blocked;
  assign w_drain  = out_valid & out_ready;
  for (genvar g = 0; g < num_ch; g++) begin : g_slot
    demux_slot #(.W(bus_size)) u_slot (
      .clk     (clk),
      .reset   (reset),
      .i_load  (w_load[g]),
      .i_drain (w_drain[g]),
      .i_data  (in),
      .o_valid (out_valid[g]),
      .o_data  (out_data[g*bus_size +: bus_size])
    );
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) r_sel_err <= 1'b0;
    else if (in_valid && !w_sel_ok) r_sel_err <= 1'b1;
  assign sel_err = r_sel_err;
`ifdef DEMUX_STATS_EN
  logic [STAT_W-1:0] r_cnt [num_ch];
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      for (int i = 0; i < num_ch; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < num_ch; i++)
        if (w_drain[i] && r_cnt[i] != STAT_MAX) r_cnt[i] <= r_cnt[i] + STAT_W'(1);
    end
  always_comb begin
    stat_count = '0;
    for (int i = 0; i < num_ch; i++)
      if (stat_sel == SEL_W'(i)) stat_count = r_cnt[i];
  end
`else
  logic w_unused_sel;
  assign w_unused_sel = ^stat_sel;
  assign stat_count   = '0;
`endif
endmodule

// File: tb/tb_demux_stream_1_n.sv
// tb_demux_stream_1_n: directed + random checks against a queue-based channel model.
module tb_demux_stream_1_n;
  logic        clk = 1'b0;
  logic        reset;
  logic        a_in_valid, a_in_ready;
  logic [3:0]  a_in;
  logic [1:0]  a_select, a_stat_sel;
  logic [3:0]  a_out_valid, a_out_ready;
  logic [15:0] a_out_data, a_stat_count;
  logic        a_sel_err;
  logic        b_in_valid, b_in_ready;
  logic [3:0]  b_in;
  logic [1:0]  b_select, b_stat_sel;
  logic [2:0]  b_out_valid, b_out_ready;
  logic [11:0] b_out_data;
  logic [15:0] b_stat_count;
  logic        b_sel_err;
  int checks = 0;
  int errors = 0;
  logic [3:0]  mq [4][$];
  logic [3:0]  last [4];
  int unsigned cnt [4];
  logic        m_rdy;
  logic        pv;
  logic [1:0]  ps;
  logic [3:0]  pd;

  always #5 clk = ~clk;

  demux_stream_1_n #(.bus_size(4), .num_ch(4)) dut_a (
    .clk(clk), .reset(reset), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in(a_in), .select(a_select), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_data(a_out_data), .sel_err(a_sel_err), .stat_sel(a_stat_sel), .stat_count(a_stat_count)
  );

  demux_stream_1_n #(.bus_size(4), .num_ch(3)) dut_b (
    .clk(clk), .reset(reset), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in(b_in), .select(b_select), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_data(b_out_data), .sel_err(b_sel_err), .stat_sel(b_stat_sel), .stat_count(b_stat_count)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < 4; k++) begin
      mq[k].delete();
      last[k] = '0;
      cnt[k] = 0;
    end
  endtask

  function automatic logic [15:0] exp_stat(input logic [1:0] ss);
`ifdef DEMUX_STATS_EN
    return 16'(cnt[ss]);
`else
    return 16'(ss & 2'b00);
`endif
  endfunction

  // one cycle: drive at negedge, check settled outputs, then advance the model at posedge
  task automatic step(input logic v, input logic [1:0] s, input logic [3:0] d,
                      input logic [3:0] rdy, input logic [1:0] ss);
    a_in_valid = v; a_select = s; a_in = d; a_out_ready = rdy; a_stat_sel = ss;
    #1;
    m_rdy = (mq[s].size() == 0) || rdy[s];
    chk("in_ready", 16'(a_in_ready), 16'(m_rdy));
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("out_valid%0d", k), 16'(a_out_valid[k]), 16'(mq[k].size() != 0));
      chk($sformatf("out_data%0d", k), 16'(a_out_data[k*4 +: 4]), 16'(last[k]));
    end
    chk("sel_err", 16'(a_sel_err), 16'd0);
    chk("stat_count", a_stat_count, exp_stat(ss));
    @(posedge clk);
    if (!reset) begin
      for (int k = 0; k < 4; k++)
        if (mq[k].size() != 0 && rdy[k]) begin
          void'(mq[k].pop_front());
          if (cnt[k] < 32'hFFFF) cnt[k]++;
        end
      if (v && m_rdy) begin
        mq[s].push_back(d);
        last[s] = d;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    b_in_valid = 1'b0; b_in = '0; b_select = '0; b_out_ready = '1; b_stat_sel = '0;
    model_clear();
    for (int n = 0; n < 3; n++) step(1'b1, 2'd0, 4'b1010, 4'hF, 2'd0);
    reset = 1'b0;
    step(1'b1, 2'd0, 4'b1010, 4'hF, 2'd0);
    step(1'b1, 2'd1, 4'b1011, 4'hF, 2'd1);
    step(1'b1, 2'd2, 4'b1111, 4'hF, 2'd2);
    step(1'b1, 2'd3, 4'b0001, 4'hF, 2'd3);
    step(1'b0, 2'd0, 4'h0, 4'hF, 2'd0);
    step(1'b0, 2'd0, 4'h0, 4'hF, 2'd0);
    step(1'b1, 2'd1, 4'h5, 4'b1101, 2'd1);
    step(1'b1, 2'd1, 4'h6, 4'b1101, 2'd1);
    step(1'b1, 2'd2, 4'h7, 4'b1101, 2'd2);
    step(1'b1, 2'd1, 4'h6, 4'b1101, 2'd1);
    step(1'b1, 2'd1, 4'h6, 4'hF, 2'd1);
    step(1'b0, 2'd1, 4'h6, 4'hF, 2'd1);
    step(1'b0, 2'd1, 4'h6, 4'hF, 2'd1);
    for (int n = 1; n <= 8; n++) step(1'b1, 2'd0, 4'(n), 4'hF, 2'd0);
    step(1'b0, 2'd0, 4'h0, 4'hF, 2'd0);
    pv = 1'b0; ps = '0; pd = '0; m_rdy = 1'b1;
    for (int n = 0; n < 400; n++) begin
      if (!(pv && !m_rdy)) begin
        pv = 1'($urandom_range(0, 1));
        ps = 2'($urandom_range(0, 3));
        pd = 4'($urandom);
      end
      step(pv, ps, pd, 4'($urandom), 2'($urandom));
    end
    for (int n = 0; n < 65540; n++) step(1'b1, 2'd2, 4'(n), 4'hF, 2'd2);
    step(1'b0, 2'd2, 4'h0, 4'hF, 2'd2);
    step(1'b0, 2'd0, 4'h0, 4'hF, 2'd2);
    chk("stat_sat", a_stat_count, exp_stat(2'd2));
    a_in_valid = 1'b0;
    b_in_valid = 1'b1; b_select = 2'd3; b_in = 4'hF;
    #1;
    chk("b_in_ready_oor", 16'(b_in_ready), 16'd1);
    @(posedge clk); @(negedge clk);
    b_in_valid = 1'b0;
    #1;
    chk("b_out_valid_oor", 16'(b_out_valid), 16'd0);
    chk("b_sel_err_set", 16'(b_sel_err), 16'd1);
    b_in_valid = 1'b1; b_select = 2'd2; b_in = 4'h9;
    #1;
    chk("b_in_ready_ch2", 16'(b_in_ready), 16'd1);
    @(posedge clk); @(negedge clk);
    b_in_valid = 1'b0;
    #1;
    chk("b_out_valid_ch2", 16'(b_out_valid), 16'b100);
    chk("b_out_data_ch2", 16'(b_out_data), 16'h900);
    chk("b_sel_err_sticky", 16'(b_sel_err), 16'd1);
    @(posedge clk); @(negedge clk);
    chk("b_out_valid_drained", 16'(b_out_valid), 16'd0);
    chk("b_out_data_hold", 16'(b_out_data), 16'h900);
    chk("b_sel_err_sticky2", 16'(b_sel_err), 16'd1);
    reset = 1'b1;
    #1;
    chk("b_sel_err_reset", 16'(b_sel_err), 16'd0);
    chk("b_out_data_reset", 16'(b_out_data), 16'd0);
    chk("a_out_valid_reset", 16'(a_out_valid), 16'd0);
    chk("a_stat_reset", a_stat_count, 16'd0);
    @(negedge clk);
    reset = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
